serial_rx_ctrl: RTL and testbench
=================================

SERIAL_RX_CTRL -- requirements
Module: serial_rx_ctrl

Interface
REQ-001 Parameter HDR_BITS, default 8; header length in bits, fixed layout {F[1:0], m[3:0], cnt[1:0]}, MSB first.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-low; sampled on rising edge of clk.
REQ-004 line  input  1  serial input; also routed externally to the receiver data pin.
REQ-005 rx_word  input  8  word from the serial receiver.
REQ-006 rx_word_ready  input  1  receiver word-complete strobe, 1 cycle.
REQ-007 rx_en  output  1  receiver enable.
REQ-008 rx_clr  output  1  receiver reset, active-high, 1-cycle pulse.
REQ-009 rx_F  output  2  receiver mode select; held for the frame.
REQ-010 rx_m  output  4  receiver modulo select; held for the frame.
REQ-011 out_word  output  8  buffered word to consumer.
REQ-012 out_valid  output  1  out_word valid.
REQ-013 out_ready  input  1  consumer accepts when out_valid & out_ready.
REQ-014 frame_done  output  1  1-cycle pulse at end of frame.
REQ-015 overrun  output  1  sticky: word lost because buffer full.

Function
REQ-016 FSM states IDLE, HDR, ACTIVE, DONE; 2-bit encoding.
REQ-017 IDLE: line=1 sampled -> HDR next cycle (start bit); rx_en=0.
REQ-018 HDR: shift line into header register one bit/cycle; after HDR_BITS bits -> ACTIVE; rx_clr pulses in the last HDR cycle.
REQ-019 On HDR->ACTIVE, latch rx_F=F, rx_m=m, word target N=cnt+1 (1..4); 3-bit word counter cleared.
REQ-020 ACTIVE: rx_en=1; each rx_word_ready increments word counter; at counter==N -> DONE on the same edge.
REQ-021 DONE: rx_en=0, frame_done=1 for exactly one cycle, rx_clr=1; -> IDLE next cycle.
REQ-022 One-entry buffer: rx_word_ready with buffer empty, or with out_valid & out_ready in the same cycle, loads out_word and sets out_valid next cycle.
REQ-023 rx_word_ready with out_valid=1 and out_ready=0: word dropped, overrun set, word still counted.
REQ-024 out_valid clears the cycle after a handshake unless reloaded per REQ-022; out_word stable while out_valid & !out_ready.
REQ-025 rx_word_ready outside ACTIVE: ignored (no count, no load, no overrun).
REQ-026 overrun clears only on reset or on IDLE->HDR transition.
REQ-027 Buffered word survives DONE/IDLE; handshake allowed in any state.
REQ-028 line during ACTIVE/DONE has no effect on the FSM.

Reset
REQ-029 reset=0 at an edge: state IDLE, header/counter 0, rx_en=0, rx_clr=1 that cycle, rx_F=0, rx_m=0, out_word=0, out_valid=0, frame_done=0, overrun=0.
REQ-030 Reset mid-frame aborts immediately; no frame_done; buffered word discarded.

Structure
REQ-031 Shared package srx_pkg: state enum, HDR_BITS, header field positions/widths, MAX_WORDS=4.
REQ-032 One sub-module srx_hdr_deser: HDR_BITS shift register plus bit counter with done strobe.

Verification
REQ-033 Idle line=0 for 20 cycles -> state IDLE, rx_en=0, no outputs.
REQ-034 line 1 then header 10_0101_01 -> rx_F=2, rx_m=5, rx_en=1; two word_ready (0xA5, 0x3C) with out_ready=1 -> both delivered, frame_done one cycle after second.
REQ-035 Header cnt=3, out_ready=0, four word_ready -> out_word=first word, overrun=1, frame_done after fourth.
REQ-036 word_ready and out_ready same cycle with out_valid=1 -> new word loaded, out_valid stays 1, overrun=0.
REQ-037 reset=0 during ACTIVE after one word -> all outputs at reset values, no frame_done; next start bit starts a clean frame.
REQ-038 rx_word_ready pulsed in IDLE -> out_valid stays 0, counter unchanged.

Source files
------------

// File: rtl/srx_pkg.sv
// Shared types and header layout for the serial receive controller.
// Header is {F, m, cnt}, shifted in MSB first.
package srx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HDR    = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam int HDR_BITS  = 8;
  localparam int F_LSB     = 6;
  localparam int F_W       = 2;
  localparam int M_LSB     = 2;
  localparam int M_W       = 4;
  localparam int CNT_LSB   = 0;
  localparam int CNT_W     = 2;
  localparam int MAX_WORDS = 4;
  localparam int WCNT_W    = 3;

  // Header cnt field encodes words-per-frame minus one.
  function automatic logic [WCNT_W-1:0] word_target(input logic [CNT_W-1:0] cnt);
    return {1'b0, cnt} + 3'd1;
  endfunction

endpackage

// File: rtl/srx_hdr_deser.sv
// Header deserializer: one bit per cycle while shift is high, done strobes on the last bit.
// hdr_nxt includes the bit being shifted this cycle so the caller can latch fields on the same edge.
module srx_hdr_deser #(
  parameter int HDR_BITS = srx_pkg::HDR_BITS
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clr,
  input  logic                shift,
  input  logic                din,
  output logic [HDR_BITS-1:0] hdr_nxt,
  output logic                pre_done,
  output logic                done
);

  localparam int CW = $clog2(HDR_BITS + 1);

  logic [HDR_BITS-1:0] hdr;
  logic [CW-1:0]       bit_cnt;

  assign hdr_nxt  = {hdr[HDR_BITS-2:0], din};
  assign done     = shift && (bit_cnt == CW'(HDR_BITS - 1));
  assign pre_done = shift && (bit_cnt == CW'(HDR_BITS - 2));

  always_ff @(posedge clk) begin
    if (!reset || clr) begin
      hdr     <= '0;
      bit_cnt <= '0;
    end else if (shift) begin
      hdr     <= hdr_nxt;
      bit_cnt <= done ? '0 : bit_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/serial_rx_ctrl.sv
// Frames a serial receiver: start bit, header, then N words into a one-entry output buffer.
// Words land in out_word one cycle after rx_word_ready; a full, unaccepted buffer drops the word and sets overrun.
module serial_rx_ctrl
  import srx_pkg::*;
#(
  parameter int HDR_BITS = srx_pkg::HDR_BITS
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       line,
  input  logic [7:0] rx_word,
  input  logic       rx_word_ready,
  output logic       rx_en,
  output logic       rx_clr,
  output logic [1:0] rx_F,
  output logic [3:0] rx_m,
  output logic [7:0] out_word,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       frame_done,
  output logic       overrun
);

  state_t              state;
  logic [WCNT_W-1:0]   word_cnt;
  logic [WCNT_W-1:0]   word_tgt;
  logic [WCNT_W-1:0]   cnt_inc;
  logic [HDR_BITS-1:0] hdr_nxt;
  logic                hdr_pre_done;
  logic                hdr_done;
  logic                word_in;

  srx_hdr_deser #(.HDR_BITS(HDR_BITS)) u_hdr_deser (
    .clk      (clk),
    .reset    (reset),
    .clr      (state == ST_IDLE),
    .shift    (state == ST_HDR),
    .din      (line),
    .hdr_nxt  (hdr_nxt),
    .pre_done (hdr_pre_done),
    .done     (hdr_done)
  );

  assign word_in = rx_word_ready && (state == ST_ACTIVE);
  assign cnt_inc = word_cnt + 3'd1;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= ST_IDLE;
      word_cnt   <= '0;
      word_tgt   <= '0;
      rx_en      <= 1'b0;
      rx_clr     <= 1'b1;
      rx_F       <= '0;
      rx_m       <= '0;
      out_word   <= '0;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      rx_clr     <= 1'b0;
      frame_done <= 1'b0;

      // Accepting a word in the same cycle as a handshake keeps the buffer full.
      if (word_in) begin
        if (!out_valid || out_ready) begin
          out_word  <= rx_word;
          out_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (line) begin
            state   <= ST_HDR;
            overrun <= 1'b0;
          end
        end
        ST_HDR: begin
          if (hdr_pre_done) rx_clr <= 1'b1;
          if (hdr_done) begin
            state    <= ST_ACTIVE;
            rx_en    <= 1'b1;
            rx_F     <= hdr_nxt[F_LSB +: F_W];
            rx_m     <= hdr_nxt[M_LSB +: M_W];
            word_tgt <= word_target(hdr_nxt[CNT_LSB +: CNT_W]);
            word_cnt <= '0;
          end
        end
        ST_ACTIVE: begin
          if (rx_word_ready) begin
            word_cnt <= cnt_inc;
            if (cnt_inc == word_tgt) begin
              state      <= ST_DONE;
              rx_en      <= 1'b0;
              rx_clr     <= 1'b1;
              frame_done <= 1'b1;
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_rx_ctrl.sv
// Directed bench for serial_rx_ctrl; delivered words are checked by a scoreboard monitor.
module tb_serial_rx_ctrl;
  import srx_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       line = 1'b0;
  logic [7:0] rx_word = 8'h00;
  logic       rx_word_ready = 1'b0;
  logic       out_ready = 1'b0;
  logic       rx_en, rx_clr, out_valid, frame_done, overrun;
  logic [1:0] rx_F;
  logic [3:0] rx_m;
  logic [7:0] out_word;

  int         vectors = 0;
  int         miscompares = 0;
  int         fd_seen = 0;
  logic [7:0] exp_q[$];
  logic [7:0] mon_exp;

  serial_rx_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .line          (line),
    .rx_word       (rx_word),
    .rx_word_ready (rx_word_ready),
    .rx_en         (rx_en),
    .rx_clr        (rx_clr),
    .rx_F          (rx_F),
    .rx_m          (rx_m),
    .out_word      (out_word),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .frame_done    (frame_done),
    .overrun       (overrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (reset) begin
      if (frame_done) fd_seen++;
      if (out_valid && out_ready) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_word: got 0x%0h, expected no delivery", out_word);
        end else begin
          mon_exp = exp_q.pop_front();
          if (out_word !== mon_exp) begin
            miscompares++;
            $display("FAIL delivered_word: got 0x%0h, expected 0x%0h", out_word, mon_exp);
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] hdr);
    line = 1'b1;
    cyc(1);
    for (int i = 0; i < 8; i++) begin
      line = hdr[7-i];
      if (i == 7) begin
        @(negedge clk);
        check("hdr_last_rx_clr", rx_clr, 1);
      end
      cyc(1);
    end
    line = 1'b0;
  endtask

  task automatic pulse_word(input logic [7:0] w);
    rx_word       = w;
    rx_word_ready = 1'b1;
    cyc(1);
    rx_word_ready = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_rx_en"}, rx_en, 0);
    check({tag, "_rx_clr"}, rx_clr, 1);
    check({tag, "_rx_F"}, rx_F, 0);
    check({tag, "_rx_m"}, rx_m, 0);
    check({tag, "_out_word"}, out_word, 0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_frame_done"}, frame_done, 0);
    check({tag, "_overrun"}, overrun, 0);
    check({tag, "_state"}, 32'(dut.state), 32'(ST_IDLE));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc(2);
    @(negedge clk);
    check_reset_vals("rst");
    cyc(1);
    reset = 1'b1;
    cyc(1);
    @(negedge clk);
    check("rst_release_rx_clr", rx_clr, 0);

    // Quiet line stays idle.
    cyc(20);
    @(negedge clk);
    check("idle_state", 32'(dut.state), 32'(ST_IDLE));
    check("idle_rx_en", rx_en, 0);
    check("idle_out_valid", out_valid, 0);
    check("idle_frames", fd_seen, 0);

    // Word strobe outside a frame is ignored.
    cyc(1);
    pulse_word(8'h77);
    @(negedge clk);
    check("idle_word_out_valid", out_valid, 0);
    check("idle_word_cnt", dut.word_cnt, 0);
    check("idle_word_overrun", overrun, 0);

    // Frame A: F=2, m=5, two words, consumer always ready.
    cyc(1);
    out_ready = 1'b1;
    send_frame(8'b10_0101_01);
    @(negedge clk);
    check("a_rx_F", rx_F, 2);
    check("a_rx_m", rx_m, 5);
    check("a_rx_en", rx_en, 1);
    cyc(1);
    exp_q.push_back(8'hA5);
    pulse_word(8'hA5);
    line = 1'b1;
    cyc(2);
    @(negedge clk);
    check("a_mid_state", 32'(dut.state), 32'(ST_ACTIVE));
    cyc(1);
    exp_q.push_back(8'h3C);
    pulse_word(8'h3C);
    line = 1'b0;
    @(negedge clk);
    check("a_frame_done", frame_done, 1);
    check("a_done_rx_en", rx_en, 0);
    check("a_done_rx_clr", rx_clr, 1);
    check("a_done_out_valid", out_valid, 1);
    cyc(1);
    @(negedge clk);
    check("a_frame_done_1cyc", frame_done, 0);
    check("a_back_idle", 32'(dut.state), 32'(ST_IDLE));

    // Frame B: four words, consumer stalled -> overrun, first word kept.
    cyc(1);
    out_ready = 1'b0;
    send_frame(8'b01_1010_11);
    @(negedge clk);
    check("b_rx_F", rx_F, 1);
    check("b_rx_m", rx_m, 4'hA);
    cyc(1);
    exp_q.push_back(8'h11);
    pulse_word(8'h11);
    pulse_word(8'h22);
    @(negedge clk);
    check("b_overrun_set", overrun, 1);
    cyc(1);
    pulse_word(8'h33);
    pulse_word(8'h44);
    @(negedge clk);
    check("b_frame_done", frame_done, 1);
    check("b_out_word", out_word, 8'h11);
    check("b_out_valid", out_valid, 1);
    check("b_overrun", overrun, 1);
    cyc(3);
    @(negedge clk);
    check("b_idle_overrun_sticky", overrun, 1);
    check("b_idle_buffer_kept", out_valid, 1);
    cyc(1);
    out_ready = 1'b1;
    cyc(1);
    @(negedge clk);
    check("b_drained", out_valid, 0);

    // Frame C: load and handshake in the same cycle.
    cyc(1);
    send_frame(8'b11_1111_01);
    @(negedge clk);
    check("c_overrun_cleared", overrun, 0);
    check("c_rx_F", rx_F, 3);
    check("c_rx_m", rx_m, 4'hF);
    cyc(1);
    exp_q.push_back(8'h5A);
    exp_q.push_back(8'hC3);
    pulse_word(8'h5A);
    pulse_word(8'hC3);
    @(negedge clk);
    check("c_out_valid_held", out_valid, 1);
    check("c_out_word_new", out_word, 8'hC3);
    check("c_overrun", overrun, 0);
    check("c_frame_done", frame_done, 1);

    // Frame D: reset after one word aborts the frame.
    cyc(3);
    out_ready = 1'b0;
    send_frame(8'b00_0011_10);
    cyc(1);
    pulse_word(8'h99);
    @(negedge clk);
    check("d_buffered", out_valid, 1);
    reset = 1'b0;
    cyc(1);
    @(negedge clk);
    check_reset_vals("d_abort");
    cyc(1);
    reset = 1'b1;
    cyc(5);
    @(negedge clk);
    check("d_no_frame_done", fd_seen, 3);
    check("d_idle_out_valid", out_valid, 0);

    // Clean frame after the abort: F=2, m=1, one word.
    cyc(1);
    out_ready = 1'b1;
    send_frame(8'b10_0001_00);
    @(negedge clk);
    check("e_rx_F", rx_F, 2);
    check("e_rx_m", rx_m, 1);
    check("e_word_cnt", dut.word_cnt, 0);
    cyc(1);
    exp_q.push_back(8'h42);
    pulse_word(8'h42);
    @(negedge clk);
    check("e_frame_done", frame_done, 1);
    cyc(3);
    @(negedge clk);
    check("total_frames", fd_seen, 4);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
